udp_tx_packetizer: RTL and testbench

//  Builds UDP datagrams from a byte stream produced by 1410 peripheral logic.

---
 rtl/udp_tx_packetizer.sv | 202 ++++++++++++++++++++
 tb/tb_udp_tx_packetizer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_packetizer.sv
// udp_tx_packetizer
//  Collects bytes from the 1410 peripheral stream into one buffer and sends
//  them as a UDP datagram (header handshake, then payload beats) when the
//  buffer fills, when flush is raised with data pending, or after an idle gap.
//
//  Optional build macro: UDP_SEQ_HEADER_EN
//   defined   - every payload starts with a 16-bit big-endian sequence number
//               (two extra beats), incremented after each completed datagram.
//   undefined - payload is exactly the buffered bytes.
//
//  Ports
//   clk, reset_n                      clock, asynchronous active-low reset
//   local_ip/remote_ip/src_port/dst_port  header config, latched on send
//   in_tdata/in_tvalid/in_tready      byte input handshake
//   flush                             send pending bytes now
//   tx_udp_hdr_*                      UDP header channel (source side)
//   tx_udp_payload_axis_*             UDP payload byte stream (source side)
//   busy                              datagram in progress (HDR or DATA)
//   dgram_count                       completed datagrams, wrapping
`timescale 1ns/1ps
module udp_tx_packetizer #(
  parameter int MAX_PAYLOAD  = 64,
  parameter int IDLE_TIMEOUT = 1000,
  parameter int ADDR_W       = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] local_ip,
  input  logic [31:0] remote_ip,
  input  logic [15:0] src_port,
  input  logic [15:0] dst_port,
  input  logic [7:0]  in_tdata,
  input  logic        in_tvalid,
  output logic        in_tready,
  input  logic        flush,
  output logic        tx_udp_hdr_valid,
  input  logic        tx_udp_hdr_ready,
  output logic [31:0] tx_udp_ip_source_ip,
  output logic [31:0] tx_udp_ip_dest_ip,
  output logic [15:0] tx_udp_source_port,
  output logic [15:0] tx_udp_dest_port,
  output logic [7:0]  tx_udp_payload_axis_tdata,
  output logic        tx_udp_payload_axis_tvalid,
  input  logic        tx_udp_payload_axis_tready,
  output logic        tx_udp_payload_axis_tlast,
  output logic        busy,
  output logic [15:0] dgram_count
);

  localparam int CNT_W  = ADDR_W + 2;
  localparam int BUF_AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
`ifdef UDP_SEQ_HEADER_EN
  localparam int PREFIX = 2;
`else
  localparam int PREFIX = 0;
`endif
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PAYLOAD);
  // Added to len to get the index of the final beat (len + PREFIX - 1).
  localparam logic [CNT_W-1:0] LAST_OFS = CNT_W'(PREFIX - 1);
  localparam logic [31:0]      IDLE_LIM = 32'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {S_FILL, S_HDR, S_DATA} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_count, r_len, r_rd;
  logic [31:0]      r_idle;
  logic             r_live;
  logic [7:0]       r_buf [0:MAX_PAYLOAD-1];
  logic [31:0]      r_src_ip, r_dst_ip;
  logic [15:0]      r_src_port, r_dst_port;
  logic [15:0]      r_dgram_count;

  logic             w_accept, w_trigger, w_beat, w_last, w_tvalid;
  logic [CNT_W-1:0] w_count_post;
  logic [7:0]       w_byte;

  // r_live keeps in_tready low while reset is held and for the partial
  // cycle after release, so every output reads 0 during reset.
  assign in_tready    = r_live && (r_state == S_FILL) && (r_count < MAX_CNT);
  assign w_accept     = in_tvalid && in_tready;
  assign w_count_post = r_count + CNT_W'(w_accept);

  // Send decision uses the count including this cycle's byte, so a flush
  // alongside a byte carries that byte in the datagram.
  assign w_trigger = (r_state == S_FILL) &&
                     ((w_count_post == MAX_CNT) ||
                      (flush && (w_count_post != '0)) ||
                      ((IDLE_TIMEOUT != 0) && (r_count != '0) && (r_idle == IDLE_LIM)));

  assign w_tvalid = (r_state == S_DATA);
  assign w_last   = (r_rd == r_len + LAST_OFS);
  assign w_beat   = w_tvalid && tx_udp_payload_axis_tready;

`ifdef UDP_SEQ_HEADER_EN
  logic [15:0]       r_seq;
  logic [BUF_AW-1:0] w_buf_idx;

  always_comb begin
    w_buf_idx = BUF_AW'(r_rd - CNT_W'(2));
    if (r_rd == '0)
      w_byte = r_seq[15:8];
    else if (r_rd == CNT_W'(1))
      w_byte = r_seq[7:0];
    else
      w_byte = r_buf[w_buf_idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_seq <= '0;
    else if (w_beat && w_last)
      r_seq <= r_seq + 16'd1;
  end
`else
  assign w_byte = r_buf[r_rd[BUF_AW-1:0]];
`endif

  assign tx_udp_hdr_valid           = (r_state == S_HDR);
  assign tx_udp_ip_source_ip        = r_src_ip;
  assign tx_udp_ip_dest_ip          = r_dst_ip;
  assign tx_udp_source_port         = r_src_port;
  assign tx_udp_dest_port           = r_dst_port;
  assign tx_udp_payload_axis_tvalid = w_tvalid;
  // Masked so tdata reads 0 outside DATA, including during reset.
  assign tx_udp_payload_axis_tdata  = w_tvalid ? w_byte : 8'h00;
  assign tx_udp_payload_axis_tlast  = w_tvalid && w_last;
  assign busy                       = (r_state != S_FILL);
  assign dgram_count                = r_dgram_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= S_FILL;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL:  if (w_trigger) w_state_nxt = S_HDR;
      S_HDR:   if (tx_udp_hdr_ready) w_state_nxt = S_DATA;
      S_DATA:  if (w_beat && w_last) w_state_nxt = S_FILL;
      default: w_state_nxt = S_FILL;
    endcase
  end

  // Buffer is LUT RAM: no reset, asynchronous read above.
  always_ff @(posedge clk) begin
    if (w_accept)
      r_buf[r_count[BUF_AW-1:0]] <= in_tdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_live        <= 1'b0;
      r_count       <= '0;
      r_len         <= '0;
      r_rd          <= '0;
      r_idle        <= '0;
      r_src_ip      <= '0;
      r_dst_ip      <= '0;
      r_src_port    <= '0;
      r_dst_port    <= '0;
      r_dgram_count <= '0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        S_FILL: begin
          r_count <= w_count_post;
          if (w_trigger) begin
            r_len      <= w_count_post;
            r_idle     <= '0;
            r_src_ip   <= local_ip;
            r_dst_ip   <= remote_ip;
            r_src_port <= src_port;
            r_dst_port <= dst_port;
          end else if (w_accept || (r_count == '0)) begin
            r_idle <= '0;
          end else begin
            r_idle <= r_idle + 32'd1;
          end
        end
        S_HDR: begin
          if (tx_udp_hdr_ready)
            r_rd <= '0;
        end
        S_DATA: begin
          if (w_beat) begin
            if (w_last) begin
              r_count       <= '0;
              r_dgram_count <= r_dgram_count + 16'd1;
            end else begin
              r_rd <= r_rd + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_packetizer.sv
`timescale 1ns/1ps
module tb_udp_tx_packetizer;

  localparam int MAXP = 64;
  localparam int IDLE = 16;
`ifdef UDP_SEQ_HEADER_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] local_ip, remote_ip;
  logic [15:0] src_port, dst_port;
  logic [7:0]  in_tdata;
  logic        in_tvalid, in_tready, flush;
  logic        tx_udp_hdr_valid, tx_udp_hdr_ready;
  logic [31:0] tx_udp_ip_source_ip, tx_udp_ip_dest_ip;
  logic [15:0] tx_udp_source_port, tx_udp_dest_port;
  logic [7:0]  tx_udp_payload_axis_tdata;
  logic        tx_udp_payload_axis_tvalid, tx_udp_payload_axis_tready, tx_udp_payload_axis_tlast;
  logic        busy;
  logic [15:0] dgram_count;

  always #5 clk = ~clk;

  udp_tx_packetizer #(.MAX_PAYLOAD(MAXP), .IDLE_TIMEOUT(IDLE), .ADDR_W(10)) dut (
    .clk(clk), .reset_n(reset_n),
    .local_ip(local_ip), .remote_ip(remote_ip), .src_port(src_port), .dst_port(dst_port),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready), .flush(flush),
    .tx_udp_hdr_valid(tx_udp_hdr_valid), .tx_udp_hdr_ready(tx_udp_hdr_ready),
    .tx_udp_ip_source_ip(tx_udp_ip_source_ip), .tx_udp_ip_dest_ip(tx_udp_ip_dest_ip),
    .tx_udp_source_port(tx_udp_source_port), .tx_udp_dest_port(tx_udp_dest_port),
    .tx_udp_payload_axis_tdata(tx_udp_payload_axis_tdata),
    .tx_udp_payload_axis_tvalid(tx_udp_payload_axis_tvalid),
    .tx_udp_payload_axis_tready(tx_udp_payload_axis_tready),
    .tx_udp_payload_axis_tlast(tx_udp_payload_axis_tlast),
    .busy(busy), .dgram_count(dgram_count)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [8:0]  exp_beats[$];   // {tlast, tdata}
  logic [95:0] exp_hdr[$];     // {src ip, dst ip, src port, dst port}
  logic [7:0]  pend[$];        // bytes accepted but not yet assigned to a datagram
  logic [15:0] seq_m = 16'd0;
  logic [15:0] dg_m  = 16'd0;
  logic        stall_q = 1'b0;
  logic [8:0]  stall_beat = 9'd0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] hdr_now();
    return {tx_udp_ip_source_ip, tx_udp_ip_dest_ip, tx_udp_source_port, tx_udp_dest_port};
  endfunction

  // Scoreboard consumer: header and payload handshakes, plus hold-while-stalled.
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q)
        chk("stall_hold", {tx_udp_payload_axis_tvalid, tx_udp_payload_axis_tlast, tx_udp_payload_axis_tdata},
            {1'b1, stall_beat});
      if (tx_udp_hdr_valid && tx_udp_hdr_ready) begin
        if (exp_hdr.size() == 0) chk("hdr_unexpected", {tx_udp_hdr_valid, hdr_now()}, 96'd0);
        else                     chk("hdr_fields", hdr_now(), exp_hdr.pop_front());
      end
      if (tx_udp_payload_axis_tvalid && tx_udp_payload_axis_tready) begin
        if (exp_beats.size() == 0)
          chk("beat_unexpected", {tx_udp_payload_axis_tvalid, tx_udp_payload_axis_tlast, tx_udp_payload_axis_tdata}, 96'd0);
        else
          chk("beat", {tx_udp_payload_axis_tlast, tx_udp_payload_axis_tdata}, exp_beats.pop_front());
      end
      stall_q    = tx_udp_payload_axis_tvalid && !tx_udp_payload_axis_tready;
      stall_beat = {tx_udp_payload_axis_tlast, tx_udp_payload_axis_tdata};
    end
  end

  task automatic expect_dgram();
    int n;
    logic [7:0] b;
    exp_hdr.push_back({local_ip, remote_ip, src_port, dst_port});
    if (SEQ_EN) begin
      exp_beats.push_back({1'b0, seq_m[15:8]});
      exp_beats.push_back({1'b0, seq_m[7:0]});
    end
    n = pend.size();
    for (int i = 0; i < n; i++) begin
      b = pend.pop_front();
      exp_beats.push_back({(i == n - 1), b});
    end
    seq_m++;
    dg_m++;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fl);
    bit ok;
    ok = 1'b0;
    in_tdata = b; in_tvalid = 1'b1; flush = fl;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (in_tready) ok = 1'b1;
    end
    @(posedge clk); #1;
    in_tvalid = 1'b0; flush = 1'b0;
    if (ok) pend.push_back(b);
    else    chk("accept_timeout", {95'd0, in_tready}, 96'd1);
  endtask

  task automatic run_until_done(input bit tog, input int hold, input bit chg_ip);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge clk); #1;
      if (tog) tx_udp_payload_axis_tready = ~tx_udp_payload_axis_tready;
      if (c == hold) tx_udp_hdr_ready = 1'b1;
      if (chg_ip && c == 3) remote_ip = ~remote_ip;
      if (busy) chk("in_tready_busy", {95'd0, in_tready}, 96'd0);
      if (tx_udp_hdr_valid && exp_hdr.size() > 0) chk("hdr_stable", hdr_now(), exp_hdr[0]);
      if (!busy && exp_beats.size() == 0 && exp_hdr.size() == 0) done = 1'b1;
    end
    if (!done) chk("dgram_timeout", 96'(exp_beats.size() + exp_hdr.size() + int'(busy)), 96'd0);
    tx_udp_payload_axis_tready = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("rst_ctrl", {tx_udp_payload_axis_tvalid, tx_udp_payload_axis_tlast, tx_udp_payload_axis_tdata,
                     tx_udp_hdr_valid, in_tready, busy, dgram_count}, 96'd0);
    chk("rst_hdr", hdr_now(), 96'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl_held", {tx_udp_payload_axis_tvalid, tx_udp_hdr_valid, in_tready, busy, dgram_count}, 96'd0);
    exp_beats.delete(); exp_hdr.delete(); pend.delete();
    seq_m = 16'd0; dg_m = 16'd0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_rst", {95'd0, in_tready}, 96'd1);
  endtask

  initial begin
    int k;
    reset_n = 1'b1;
    local_ip = 32'h0A00_0001; remote_ip = 32'h0A00_0002;
    src_port = 16'd5000;      dst_port = 16'd6000;
    in_tdata = 8'h00; in_tvalid = 1'b0; flush = 1'b0;
    tx_udp_hdr_ready = 1'b1; tx_udp_payload_axis_tready = 1'b1;

    // Reset state
    do_reset();

    // Full buffer: 64 bytes 00..3F
    for (int i = 0; i < MAXP; i++) send_byte(8'(i), 1'b0);
    chk("full_hdr_latency", {94'd0, tx_udp_hdr_valid, in_tready}, 96'd2);
    expect_dgram();
    run_until_done(1'b0, 0, 1'b0);
    chk("dgram_count_full", {80'd0, dgram_count}, {80'd0, dg_m});

    // Idle timeout
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    expect_dgram();
    k = 0;
    for (int j = 1; j <= 40 && k == 0; j++) begin
      @(posedge clk); #1;
      if (tx_udp_hdr_valid) k = j;
    end
    chk("idle_latency", 96'(k), 96'd17);
    run_until_done(1'b0, 0, 1'b0);

    // Flush with empty buffer is ignored
    flush = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      chk("flush_empty_busy", {95'd0, busy}, 96'd0);
    end
    flush = 1'b0;
    chk("flush_empty_count", {80'd0, dgram_count}, {80'd0, dg_m});

    // Flush together with the 5th byte
    for (int i = 0; i < 4; i++) send_byte(8'h50 + 8'(i), 1'b0);
    send_byte(8'h54, 1'b1);
    chk("flush_hdr", {95'd0, tx_udp_hdr_valid}, 96'd1);
    expect_dgram();
    run_until_done(1'b0, 0, 1'b0);
    chk("dgram_count_flush", {80'd0, dgram_count}, {80'd0, dg_m});

    // Header stall, config change in HDR, payload backpressure toggling
    local_ip = 32'hC0A8_0101; remote_ip = 32'hC0A8_0202; src_port = 16'h1234; dst_port = 16'h4321;
    tx_udp_hdr_ready = 1'b0; tx_udp_payload_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(8'hE0 + 8'(i), 1'b0);
    send_byte(8'hE5, 1'b1);
    expect_dgram();
    run_until_done(1'b1, 10, 1'b1);
    chk("dgram_count_stall", {80'd0, dgram_count}, {80'd0, dg_m});

    // Two short datagrams from a fresh reset (sequence starts at 0)
    do_reset();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    expect_dgram();
    run_until_done(1'b0, 0, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    expect_dgram();
    run_until_done(1'b0, 0, 1'b0);
    chk("dgram_count_two", {80'd0, dgram_count}, {80'd0, dg_m});

    // Reset in the middle of DATA
    tx_udp_payload_axis_tready = 1'b0;
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    send_byte(8'h77, 1'b1);
    expect_dgram();
    k = 0;
    for (int j = 1; j <= 20 && k == 0; j++) begin
      @(posedge clk); #1;
      if (tx_udp_payload_axis_tvalid) k = j;
    end
    chk("mid_data_reached", {95'd0, tx_udp_payload_axis_tvalid}, 96'd1);
    do_reset();
    tx_udp_payload_axis_tready = 1'b1;
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b1);
    expect_dgram();
    run_until_done(1'b0, 0, 1'b0);
    chk("dgram_count_recover", {80'd0, dgram_count}, {80'd0, dg_m});

    chk("queues_drained", 96'(exp_beats.size() + exp_hdr.size() + pend.size()), 96'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
